// File: rtl/pcg_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pcg_share_ctrl
// Description : Shares one PCG-XSH-RR generator among NREQ requesters. Loads
//               the seed, runs the warm-up draws, then grants draws to the
//               requesters in round-robin order. Each grant takes three
//               cycles (IDLE -> ISSUE -> DELIVER).
// Ports       : clk, rst           - clock, synchronous active-high reset
//               req                - level request per client
//               rsp_valid/id/data  - one-cycle response, one-hot owner, word
//               reseed, seed_in    - one-cycle seed load request and seed value
//               busy               - high while seeding or warming up
//               pcg_rst/en/seed    - control outputs to the generator
//               pcg_out            - generator output word
// Revision    : 1.0 - initial release
// ============================================================================
module pcg_share_ctrl #(
    parameter int          NREQ         = 4,
    parameter int          WARMUP       = 4,
    parameter logic [63:0] DEFAULT_SEED = 64'hD4E12F77CAFEBABE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic            rsp_valid,
    output logic [NREQ-1:0] rsp_id,
    output logic [31:0]     rsp_data,
    input  logic            reseed,
    input  logic [63:0]     seed_in,
    output logic            busy,
    output logic            pcg_rst,
    output logic            pcg_en,
    output logic [63:0]     pcg_seed,
    input  logic [31:0]     pcg_out
);

    localparam int          c_IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  c_WARM_LAST = 8'((WARMUP > 0) ? WARMUP - 1 : 0);

    localparam logic [2:0]  c_SEED      = 3'd0;
    localparam logic [2:0]  c_WARM      = 3'd1;
    localparam logic [2:0]  c_IDLE      = 3'd2;
    localparam logic [2:0]  c_ISSUE     = 3'd3;
    localparam logic [2:0]  c_DELIVER   = 3'd4;

    // With no warm-up the generator is usable straight after the seed load.
    localparam logic [2:0]  c_AFTER_SEED = (WARMUP > 0) ? c_WARM : c_IDLE;

    logic [2:0]          r_state;
    logic [7:0]          r_cnt;
    logic [c_IDX_W-1:0]  r_start;      // first index searched by the arbiter
    logic [c_IDX_W-1:0]  r_win_idx;
    logic [NREQ-1:0]     r_win;
    logic                r_pend;
    logic [63:0]         r_pend_seed;
    logic [63:0]         r_seed;

    logic [NREQ-1:0]     w_mask;
    logic [NREQ-1:0]     w_masked;
    logic [NREQ-1:0]     w_pick;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_found;
    logic [NREQ-1:0]     w_onehot;
    logic [c_IDX_W-1:0]  w_next_start;
    logic                w_reseed_any;
    logic [63:0]         w_new_seed;

    // Round-robin: look first at requests at or above r_start; if there are
    // none, wrap around and take the lowest set request overall.
    assign w_mask   = ~((NREQ'(1) << r_start) - NREQ'(1));
    assign w_masked = req & w_mask;
    assign w_pick   = (|w_masked) ? w_masked : req;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && w_pick[j]) begin
                w_found = 1'b1;
                w_idx   = c_IDX_W'(j);
            end
        end
    end

    assign w_onehot     = NREQ'(1) << w_idx;
    assign w_next_start = (r_win_idx == c_IDX_W'(NREQ - 1)) ? '0
                                                             : r_win_idx + c_IDX_W'(1);

    // A reseed pulse in the current cycle is newer than any pending one.
    assign w_reseed_any = reseed | r_pend;
    assign w_new_seed   = reseed ? seed_in : r_pend_seed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_SEED;
            r_cnt       <= 8'd0;
            r_start     <= '0;
            r_win_idx   <= '0;
            r_win       <= '0;
            r_pend      <= 1'b0;
            r_pend_seed <= 64'd0;
            r_seed      <= DEFAULT_SEED;
        end else begin
            case (r_state)
                c_SEED: begin
                    // A new seed here restarts the load with that seed.
                    if (reseed) begin
                        r_seed <= seed_in;
                    end else begin
                        r_state <= c_AFTER_SEED;
                        r_cnt   <= 8'd0;
                    end
                end
                c_WARM: begin
                    if (reseed) begin
                        r_pend      <= 1'b1;
                        r_pend_seed <= seed_in;
                    end
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == c_WARM_LAST) begin
                        r_state <= c_IDLE;
                    end
                end
                c_IDLE: begin
                    if (w_reseed_any) begin
                        r_state <= c_SEED;
                        r_seed  <= w_new_seed;
                        r_pend  <= 1'b0;
                    end else if (|req) begin
                        r_state   <= c_ISSUE;
                        r_win_idx <= w_idx;
                        r_win     <= w_onehot;
                    end
                end
                c_ISSUE: begin
                    if (reseed) begin
                        r_pend      <= 1'b1;
                        r_pend_seed <= seed_in;
                    end
                    r_state <= c_DELIVER;
                end
                c_DELIVER: begin
                    r_start <= w_next_start;
                    if (w_reseed_any) begin
                        r_state <= c_SEED;
                        r_seed  <= w_new_seed;
                        r_pend  <= 1'b0;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_SEED;
                end
            endcase
        end
    end

    // The generator steps at the end of ISSUE, so its output is fresh in
    // DELIVER and can be forwarded without another register stage.
    assign pcg_rst   = (r_state == c_SEED);
    assign pcg_en    = (r_state == c_WARM) || (r_state == c_ISSUE);
    assign busy      = (r_state == c_SEED) || (r_state == c_WARM);
    assign rsp_valid = (r_state == c_DELIVER);
    assign rsp_id    = rsp_valid ? r_win : '0;
    assign rsp_data  = rsp_valid ? pcg_out : 32'd0;
    assign pcg_seed  = r_seed;

endmodule
`default_nettype wire

// File: tb/tb_pcg_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcg_share_ctrl
// Description : Self-checking bench for pcg_share_ctrl. Includes a generator
//               model for pcg_out, directed vector tables, and a randomized
//               phase checked against a round-robin / golden-draw reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcg_share_ctrl;

    localparam int          NREQ   = 4;
    localparam int          WARMUP = 4;
    localparam logic [63:0] DEF    = 64'hD4E12F77CAFEBABE;
    localparam logic [63:0] MULT   = 64'd6364136223846793005;
    localparam logic [63:0] INC    = 64'd1442695040888963407;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        rsp_valid;
    logic [3:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        reseed;
    logic [63:0] seed_in;
    logic        busy;
    logic        pcg_rst;
    logic        pcg_en;
    logic [63:0] pcg_seed;
    logic [31:0] pcg_out;

    int total = 0;
    int bad   = 0;

    pcg_share_ctrl #(.NREQ(NREQ), .WARMUP(WARMUP), .DEFAULT_SEED(DEF)) dut (
        .clk(clk), .rst(rst), .req(req), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .reseed(reseed), .seed_in(seed_in), .busy(busy),
        .pcg_rst(pcg_rst), .pcg_en(pcg_en), .pcg_seed(pcg_seed), .pcg_out(pcg_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] xsh(input logic [63:0] s);
        logic [31:0] x;
        int          r;
        x = 32'(((s >> 18) ^ s) >> 27);
        r = int'(s[63:59]);
        return (x >> r) | (x << ((32 - r) % 32));
    endfunction

    // n-th output word (1-based) of a generator freshly loaded with seed.
    function automatic logic [31:0] golden(input logic [63:0] seed, input int n);
        logic [63:0] s;
        logic [31:0] o;
        s = seed;
        o = 32'd0;
        for (int i = 0; i < n; i++) begin
            o = xsh(s);
            s = s * MULT + INC;
        end
        return o;
    endfunction

    function automatic int rr(input int last, input logic [3:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    // Generator environment model.
    logic [63:0] pcg_state;
    always @(posedge clk) begin
        if (pcg_rst) begin
            pcg_state <= pcg_seed;
            pcg_out   <= 32'd0;
        end else if (pcg_en) begin
            pcg_out   <= xsh(pcg_state);
            pcg_state <= pcg_state * MULT + INC;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) chk("en_rst_exclusive", 64'(pcg_en & pcg_rst), 64'd0);
    end

    task automatic do_reset();
        int nr, ne, nb, nv;
        rst = 1'b1; req = 4'd0; reseed = 1'b0;
        @(negedge clk);
        chk("reset_no_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("reset_rsp", {31'd0, rsp_valid, rsp_id, rsp_data}, 64'd0);
        chk("reset_en", 64'(pcg_en), 64'd0);
        chk("reset_pcg_rst_busy", 64'({pcg_rst, busy}), 64'd3);
        chk("reset_seed", pcg_seed, DEF);
        rst = 1'b0;
        nr = int'(pcg_rst); ne = int'(pcg_en); nb = int'(busy); nv = int'(rsp_valid);
        repeat (WARMUP) begin
            @(negedge clk);
            nr += int'(pcg_rst); ne += int'(pcg_en); nb += int'(busy); nv += int'(rsp_valid);
        end
        @(negedge clk);
        chk("seq_busy_drop", 64'(busy), 64'd0);
        chk("seq_pcg_rst_cycles", 64'(nr), 64'd1);
        chk("seq_warm_cycles", 64'(ne), 64'(WARMUP));
        chk("seq_busy_cycles", 64'(nb), 64'(WARMUP + 1));
        chk("seq_no_valid", 64'(nv + int'(rsp_valid)), 64'd0);
    endtask

    task automatic expect_rsp(input string nm, input logic [3:0] id,
                              input logic [31:0] data, input int gap);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 12);
        chk({nm, "_valid"}, 64'(rsp_valid), 64'd1);
        if (rsp_valid) begin
            chk({nm, "_id"}, 64'(rsp_id), 64'(id));
            chk({nm, "_data"}, 64'(rsp_data), 64'(data));
            if (gap > 0) chk({nm, "_latency"}, 64'(n), 64'(gap));
        end
    endtask

    typedef struct {
        logic [3:0]      req;
        int              n;
        logic [4:0][3:0] ids;
    } vec_t;

    function automatic logic [4:0][3:0] mk(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] c, input logic [3:0] d,
                                           input logic [3:0] e);
        return {e, d, c, b, a};
    endfunction

    typedef struct {
        int          idx;
        logic [63:0] seed;
    } rs_t;

    vec_t        tbl [5];
    logic [3:0]  hist [0:3199];
    rs_t         rsq [$];

    initial begin
        int          k, last, w, gap;
        logic [63:0] cur_seed;
        logic [3:0]  lr, nreq;
        bit          drain;

        tbl[0] = '{req: 4'b1111, n: 5, ids: mk(4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001)};
        tbl[1] = '{req: 4'b0001, n: 3, ids: mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000)};
        tbl[2] = '{req: 4'b0010, n: 1, ids: mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000)};
        tbl[3] = '{req: 4'b1010, n: 3, ids: mk(4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000)};
        tbl[4] = '{req: 4'b0110, n: 3, ids: mk(4'b0010, 4'b0100, 4'b0010, 4'b0000, 4'b0000)};

        rst = 1'b1; req = 4'd0; reseed = 1'b0; seed_in = 64'd0;
        do_reset();

        // Back-to-back held requests: one word every three cycles.
        k = WARMUP + 1;
        for (int i = 0; i < 5; i++) begin
            req = tbl[i].req;
            for (int j = 0; j < tbl[i].n; j++) begin
                gap = (i == 0 && j == 0) ? 2 : 3;
                expect_rsp("tbl", tbl[i].ids[j], golden(DEF, k), gap);
                k++;
            end
        end

        // Reseed arriving during DELIVER: response completes, then reload.
        req = 4'b0001;
        expect_rsp("reseed_draw", 4'b0001, golden(DEF, k), 3);
        reseed = 1'b1; seed_in = 64'd1; req = 4'd0;
        @(negedge clk);
        reseed = 1'b0;
        chk("reseed_pcg_rst", 64'(pcg_rst), 64'd1);
        chk("reseed_seed", pcg_seed, 64'd1);
        chk("reseed_busy", 64'(busy), 64'd1);
        repeat (WARMUP) begin
            @(negedge clk);
            chk("reseed_warm_en", 64'(pcg_en), 64'd1);
        end
        @(negedge clk);
        chk("reseed_idle", 64'(busy), 64'd0);
        req = 4'b0001;
        expect_rsp("seed1_first", 4'b0001, golden(64'd1, WARMUP + 1), 2);
        req = 4'd0;

        // Reset lands right after ISSUE: the draw is dropped.
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        chk("abort_issue_en", 64'(pcg_en), 64'd1);
        do_reset();
        req = 4'b0001;
        expect_rsp("after_abort", 4'b0001, golden(DEF, WARMUP + 1), 2);
        req = 4'd0;

        // Randomized phase.
        do_reset();
        last = NREQ - 1; cur_seed = DEF; k = WARMUP + 1;
        for (int n = 0; n < 3200; n++) begin
            drain = (n >= 2900);
            lr = (n >= 2) ? hist[n - 2] : 4'd0;
            if (rsp_valid) begin
                while (rsq.size() > 0 && rsq[0].idx <= n - 2) begin
                    cur_seed = rsq[0].seed;
                    k = WARMUP + 1;
                    void'(rsq.pop_front());
                end
                chk("rnd_req_present", 64'(lr != 4'd0), 64'd1);
                if (lr != 4'd0) begin
                    w = rr(last, lr);
                    chk("rnd_id", 64'(rsp_id), 64'(4'b0001 << w));
                    chk("rnd_data", 64'(rsp_data), 64'(golden(cur_seed, k)));
                    last = w;
                    k++;
                end
            end else begin
                chk("rnd_quiet", {28'd0, rsp_id, rsp_data}, 64'd0);
            end
            nreq = req;
            if (rsp_valid && (drain || $urandom_range(0, 3) != 0)) nreq = nreq & ~rsp_id;
            if (!drain) nreq = nreq | (4'($urandom) & 4'($urandom));
            reseed = 1'b0;
            if (!drain && $urandom_range(0, 59) == 0) begin
                reseed  = 1'b1;
                seed_in = {$urandom, $urandom};
                rsq.push_back('{idx: n, seed: seed_in});
            end
            req = nreq;
            hist[n] = nreq;
            @(negedge clk);
        end
        chk("drain_all_served", 64'(req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
